// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data SRAM access controller between EX and MEM stages
// One load/store in flight; formats store lanes, holds the read word, drains flushed accesses.
module dmem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_req_i,
   input  logic              ex_wr_i,
   input  logic [1:0]        ex_size_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              mem_stall_i,
   input  logic              flush_i,
   output logic              data_req_o,
   output logic              data_wr_o,
   output logic [1:0]        data_size_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [3:0]        data_wstrb_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic              data_addr_ok_i,
   input  logic              data_data_ok_i,
   input  logic [DATA_W-1:0] data_rdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic [1:0]        addr_low_o,
   output logic              misalign_o,
   output logic              stall_o
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

   state_t              state_q, state_d;
   logic                killed_q, killed_d;
   logic                wr_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, wdata_fmt;
   logic [3:0]          wstrb_q, wstrb_fmt;
   logic [DATA_W-1:0]   rdata_q;
   logic                accept;
   logic                capture;

   always_comb begin
      misalign_o = 1'b0;
      if (ex_req_i) begin
         if (ex_size_i == 2'd1)
            misalign_o = ex_addr_i[0];
         else if (ex_size_i[1])
            misalign_o = (ex_addr_i[1:0] != 2'b00);
      end
   end

   assign accept = (state_q == IDLE) && ex_req_i && !misalign_o && !flush_i;

   // Lane replication lets the SRAM pick the byte lane from the strobes alone.
   always_comb begin
      wdata_fmt = ex_wdata_i;
      wstrb_fmt = 4'b1111;
      case (ex_size_i)
         2'd0: begin
            wdata_fmt = {4{ex_wdata_i[7:0]}};
            wstrb_fmt = 4'b0001 << ex_addr_i[1:0];
         end
         2'd1: begin
            wdata_fmt = {2{ex_wdata_i[15:0]}};
            wstrb_fmt = ex_addr_i[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_fmt = ex_wdata_i;
            wstrb_fmt = 4'b1111;
         end
      endcase
      if (!ex_wr_i)
         wstrb_fmt = 4'b0000;
   end

   always_comb begin
      state_d  = state_q;
      killed_d = killed_q;
      case (state_q)
         IDLE: if (accept) state_d = REQ;
         REQ: begin
            if (flush_i)
               killed_d = 1'b1;
            // data_ok seen before addr_ok is ignored; only addr_ok moves on.
            if (data_addr_ok_i)
               state_d = (killed_q || flush_i) ? DRAIN : WAIT;
         end
         WAIT: begin
            if (flush_i)
               state_d = data_data_ok_i ? IDLE : DRAIN;
            else if (data_data_ok_i)
               state_d = DONE;
         end
         DONE:  if (flush_i || !mem_stall_i) state_d = IDLE;
         DRAIN: if (data_data_ok_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE)
         killed_d = 1'b0;
   end

   assign capture = (state_q == WAIT) && data_data_ok_i && !flush_i && !wr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         killed_q <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= 4'b0000;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         killed_q <= killed_d;
         if (accept) begin
            wr_q    <= ex_wr_i;
            size_q  <= ex_size_i;
            addr_q  <= ex_addr_i;
            wdata_q <= wdata_fmt;
            wstrb_q <= wstrb_fmt;
         end
         if (capture)
            rdata_q <= data_rdata_i;
      end
   end

   always_comb begin
      data_req_o    = (state_q == REQ);
      rdata_valid_o = (state_q == DONE);
      stall_o       = accept || (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
   end

   assign data_wr_o    = wr_q;
   assign data_size_o  = size_q;
   assign data_addr_o  = addr_q;
   assign data_wstrb_o = wstrb_q;
   assign data_wdata_o = wdata_q;
   assign rdata_o      = rdata_q;
   assign addr_low_o   = addr_q[1:0];

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed scoreboard bench for dmem_ctrl
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_req_i, ex_wr_i, mem_stall_i, flush_i;
   logic [1:0]  ex_size_i;
   logic [31:0] ex_addr_i, ex_wdata_i;
   logic        data_req_o, data_wr_o;
   logic [1:0]  data_size_o;
   logic [31:0] data_addr_o;
   logic [3:0]  data_wstrb_o;
   logic [31:0] data_wdata_o;
   logic        data_addr_ok_i, data_data_ok_i;
   logic [31:0] data_rdata_i;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic [1:0]  addr_low_o;
   logic        misalign_o, stall_o;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd = 32'h0;

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ex_req_i(ex_req_i), .ex_wr_i(ex_wr_i), .ex_size_i(ex_size_i),
      .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
      .mem_stall_i(mem_stall_i), .flush_i(flush_i),
      .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
      .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
      .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
      .data_rdata_i(data_rdata_i),
      .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .addr_low_o(addr_low_o),
      .misalign_o(misalign_o), .stall_o(stall_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop();
      chk("sb_valid", {31'd0, rdata_valid_o}, 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL sb_empty observed=completion expected=none");
      end else begin
         chk("sb_rdata", rdata_o, exp_q.pop_front());
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
      ex_req_i   = 1'b1;
      ex_wr_i    = wr;
      ex_size_i  = size;
      ex_addr_i  = addr;
      ex_wdata_i = wdata;
   endtask

   task automatic store_zw(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      issue(1'b1, size, addr, wdata);
      settle();
      chk("st_c0_stall", {31'd0, stall_o}, 32'd1);
      exp_q.push_back(last_rd);
      step();
      ex_req_i = 1'b0;
      data_addr_ok_i = 1'b1;
      settle();
      chk("st_req", {31'd0, data_req_o}, 32'd1);
      chk("st_wr", {31'd0, data_wr_o}, 32'd1);
      chk("st_size", {30'd0, data_size_o}, {30'd0, size});
      chk("st_wstrb", {28'd0, data_wstrb_o}, {28'd0, exp_strb});
      chk("st_wdata", data_wdata_o, exp_wdata);
      step();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'h7777_7777;
      step();
      data_data_ok_i = 1'b0;
      settle();
      sb_pop();
      chk("st_done_stall", {31'd0, stall_o}, 32'd0);
      step();
      settle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ex_req_i = 1'b0; ex_wr_i = 1'b0; ex_size_i = 2'd0; ex_addr_i = '0; ex_wdata_i = '0;
      mem_stall_i = 1'b0; flush_i = 1'b0;
      data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'd0, data_req_o}, 32'd0);
      chk("rst_wr", {31'd0, data_wr_o}, 32'd0);
      chk("rst_size", {30'd0, data_size_o}, 32'd0);
      chk("rst_addr", data_addr_o, 32'd0);
      chk("rst_wstrb", {28'd0, data_wstrb_o}, 32'd0);
      chk("rst_wdata", data_wdata_o, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("rst_alow", {30'd0, addr_low_o}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      rst = 1'b0;
      step();

      // zero-wait load word
      issue(1'b0, 2'd2, 32'h1000_0004, 32'h0);
      settle();
      chk("ld_c0_stall", {31'd0, stall_o}, 32'd1);
      chk("ld_c0_req", {31'd0, data_req_o}, 32'd0);
      exp_q.push_back(32'hDEAD_BEEF);
      last_rd = 32'hDEAD_BEEF;
      step();
      ex_req_i = 1'b0;
      data_addr_ok_i = 1'b1;
      settle();
      chk("ld_c1_req", {31'd0, data_req_o}, 32'd1);
      chk("ld_c1_addr", data_addr_o, 32'h1000_0004);
      chk("ld_c1_wstrb", {28'd0, data_wstrb_o}, 32'd0);
      chk("ld_c1_stall", {31'd0, stall_o}, 32'd1);
      step();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i = 32'hDEAD_BEEF;
      settle();
      chk("ld_c2_req", {31'd0, data_req_o}, 32'd0);
      chk("ld_c2_stall", {31'd0, stall_o}, 32'd1);
      chk("ld_c2_valid", {31'd0, rdata_valid_o}, 32'd0);
      step();
      data_data_ok_i = 1'b0;
      settle();
      sb_pop();
      chk("ld_c3_stall", {31'd0, stall_o}, 32'd0);
      chk("ld_c3_alow", {30'd0, addr_low_o}, 32'd0);
      step();
      settle();
      chk("ld_c4_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("ld_c4_stall", {31'd0, stall_o}, 32'd0);

      // store formatting
      store_zw(2'd0, 32'h1000_0003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
      store_zw(2'd1, 32'h1000_0002, 32'h0000_1234, 4'b1100, 32'h1234_1234);
      store_zw(2'd0, 32'h1000_0001, 32'hFFFF_FF3C, 4'b0010, 32'h3C3C_3C3C);
      store_zw(2'd3, 32'h1000_0008, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);

      // misalignment
      issue(1'b0, 2'd1, 32'h1000_0001, 32'h0);
      settle();
      chk("mis_half", {31'd0, misalign_o}, 32'd1);
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      step();
      settle();
      chk("mis_req", {31'd0, data_req_o}, 32'd0);
      chk("mis_idle_stall", {31'd0, stall_o}, 32'd0);
      ex_size_i = 2'd2;
      ex_addr_i = 32'h1000_0002;
      settle();
      chk("mis_word", {31'd0, misalign_o}, 32'd1);
      ex_req_i = 1'b0;
      settle();
      chk("mis_gated", {31'd0, misalign_o}, 32'd0);
      step();
      settle();
      chk("mis_no_req", {31'd0, data_req_o}, 32'd0);

      // delayed handshakes on a store word
      issue(1'b1, 2'd2, 32'h2000_0008, 32'hCAFE_F00D);
      settle();
      exp_q.push_back(last_rd);
      step();
      ex_req_i = 1'b0;
      ex_addr_i = 32'h0;
      ex_wdata_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         data_addr_ok_i = (i == 3);
         settle();
         chk("dly_req", {31'd0, data_req_o}, 32'd1);
         chk("dly_addr", data_addr_o, 32'h2000_0008);
         chk("dly_wdata", data_wdata_o, 32'hCAFE_F00D);
         chk("dly_stall", {31'd0, stall_o}, 32'd1);
         step();
      end
      data_addr_ok_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_data_ok_i = (i == 2);
         settle();
         chk("dly_wait_req", {31'd0, data_req_o}, 32'd0);
         chk("dly_wait_stall", {31'd0, stall_o}, 32'd1);
         step();
      end
      data_data_ok_i = 1'b0;
      settle();
      sb_pop();
      chk("dly_done_stall", {31'd0, stall_o}, 32'd0);
      step();
      settle();

      // flush in WAIT
      issue(1'b0, 2'd2, 32'h3000_0000, 32'h0);
      settle();
      step();
      ex_req_i = 1'b0;
      data_addr_ok_i = 1'b1;
      settle();
      step();
      data_addr_ok_i = 1'b0;
      flush_i = 1'b1;
      settle();
      chk("fw_stall", {31'd0, stall_o}, 32'd1);
      step();
      flush_i = 1'b0;
      settle();
      chk("fw_drain_stall", {31'd0, stall_o}, 32'd1);
      chk("fw_drain_valid", {31'd0, rdata_valid_o}, 32'd0);
      step();
      data_data_ok_i = 1'b1;
      data_rdata_i = 32'h0000_0055;
      settle();
      chk("fw_dok_valid", {31'd0, rdata_valid_o}, 32'd0);
      step();
      data_data_ok_i = 1'b0;
      settle();
      chk("fw_end_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("fw_end_rdata", rdata_o, last_rd);
      chk("fw_end_stall", {31'd0, stall_o}, 32'd0);

      // flush in REQ
      issue(1'b0, 2'd2, 32'h3000_0010, 32'h0);
      settle();
      step();
      ex_req_i = 1'b0;
      flush_i = 1'b1;
      settle();
      chk("fr_req0", {31'd0, data_req_o}, 32'd1);
      step();
      flush_i = 1'b0;
      data_addr_ok_i = 1'b1;
      settle();
      chk("fr_req1", {31'd0, data_req_o}, 32'd1);
      chk("fr_stall", {31'd0, stall_o}, 32'd1);
      step();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i = 32'h0000_0066;
      settle();
      chk("fr_drain_req", {31'd0, data_req_o}, 32'd0);
      chk("fr_drain_stall", {31'd0, stall_o}, 32'd1);
      chk("fr_drain_valid", {31'd0, rdata_valid_o}, 32'd0);
      step();
      data_data_ok_i = 1'b0;
      settle();
      chk("fr_end_rdata", rdata_o, last_rd);
      chk("fr_end_stall", {31'd0, stall_o}, 32'd0);
      chk("fr_end_valid", {31'd0, rdata_valid_o}, 32'd0);

      // DONE held by mem_stall with ex_req held; early data_ok in REQ ignored
      issue(1'b0, 2'd2, 32'h4000_0008, 32'h0);
      mem_stall_i = 1'b1;
      settle();
      exp_q.push_back(32'h0BAD_F00D);
      last_rd = 32'h0BAD_F00D;
      step();
      data_addr_ok_i = 1'b1;
      data_data_ok_i = 1'b1;
      data_rdata_i = 32'h1111_1111;
      settle();
      step();
      data_addr_ok_i = 1'b0;
      data_rdata_i = 32'h0BAD_F00D;
      settle();
      chk("ms_wait_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("ms_wait_stall", {31'd0, stall_o}, 32'd1);
      step();
      data_data_ok_i = 1'b0;
      settle();
      sb_pop();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            step();
            settle();
         end
         chk("ms_valid", {31'd0, rdata_valid_o}, 32'd1);
         chk("ms_req", {31'd0, data_req_o}, 32'd0);
         chk("ms_stall", {31'd0, stall_o}, 32'd0);
      end
      step();
      mem_stall_i = 1'b0;
      ex_req_i = 1'b0;
      settle();
      chk("ms_last_valid", {31'd0, rdata_valid_o}, 32'd1);
      step();
      settle();
      chk("ms_idle_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("ms_idle_req", {31'd0, data_req_o}, 32'd0);
      chk("ms_idle_stall", {31'd0, stall_o}, 32'd0);

      // flush in DONE overrides mem_stall
      issue(1'b0, 2'd2, 32'h4000_0000, 32'h0);
      mem_stall_i = 1'b1;
      settle();
      exp_q.push_back(32'h2468_ACE0);
      last_rd = 32'h2468_ACE0;
      step();
      ex_req_i = 1'b0;
      data_addr_ok_i = 1'b1;
      settle();
      step();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i = 32'h2468_ACE0;
      settle();
      step();
      data_data_ok_i = 1'b0;
      flush_i = 1'b1;
      settle();
      sb_pop();
      step();
      flush_i = 1'b0;
      mem_stall_i = 1'b0;
      settle();
      chk("fd_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("fd_stall", {31'd0, stall_o}, 32'd0);

      // async reset while in WAIT
      issue(1'b0, 2'd2, 32'h5000_0004, 32'h0);
      settle();
      step();
      ex_req_i = 1'b0;
      data_addr_ok_i = 1'b1;
      settle();
      step();
      data_addr_ok_i = 1'b0;
      settle();
      chk("ar_wait_stall", {31'd0, stall_o}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_stall", {31'd0, stall_o}, 32'd0);
      chk("ar_addr", data_addr_o, 32'd0);
      chk("ar_rdata", rdata_o, 32'd0);
      chk("ar_alow", {30'd0, addr_low_o}, 32'd0);
      chk("ar_valid", {31'd0, rdata_valid_o}, 32'd0);
      step();
      rst = 1'b0;
      step();
      settle();
      chk("ar_idle_req", {31'd0, data_req_o}, 32'd0);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-SRAM access controller between EX and MEM stages. Sequences one load/store at a time over an SRAM-like req/addr_ok/data_ok bus.
- Formats store data and byte strobes, and detects misalignment.
- Drives the pipeline stall until read data is captured.
- Holds the raw read word and address low bits for MEM-stage load extraction. Drops flushed accesses safely.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width (fixed 4 byte lanes)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- ex_req_i  in  1  EX stage holds a valid load/store
- ex_wr_i  in  1  1=store, 0=load
- ex_size_i  in  2  0=byte, 1=half, 2=word; 3 treated as word
- ex_addr_i  in  ADDR_W  effective address
- ex_wdata_i  in  32  unformatted store source register
- mem_stall_i  in  1  downstream pipeline stall
- flush_i  in  1  pipeline flush (exception/eret)
- data_req_o  out  1  bus request
- data_wr_o  out  1  bus write
- data_size_o  out  2  bus size (= latched ex_size_i)
- data_addr_o  out  ADDR_W  bus address (latched, low bits unmodified)
- data_wstrb_o  out  4  byte enables; 0 for loads
- data_wdata_o  out  32  lane-replicated store data
- data_addr_ok_i  in  1  address accepted
- data_data_ok_i  in  1  read data valid / write complete
- data_rdata_i  in  32  read data
- rdata_o  out  32  captured raw read word
- rdata_valid_o  out  1  rdata_o/completion valid for current instruction
- addr_low_o  out  2  latched address [1:0] for load extraction
- misalign_o  out  1  combinational alignment fault on ex_req_i
- stall_o  out  1  stall request to pipeline

Behaviour:
- Reset: state IDLE, killed=0. All outputs 0: data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o, rdata_o, rdata_valid_o, addr_low_o, stall_o. misalign_o depends on inputs only.
- Misalign (combinational): half with addr[0]=1, or word with addr[1:0]!=0, gated by ex_req_i. A misaligned access never enters the FSM or the bus; stall_o is not raised for it.
- Accept condition: IDLE & ex_req_i & ~misalign_o & ~flush_i.
- On accept, latch wr, size, addr, formatted wdata and wstrb.
  - Byte: wdata={4{b[7:0]}}, wstrb=0001<<addr[1:0].
  - Half: wdata={2{h[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - Word: wdata as is, wstrb=1111.
  - Load: wstrb=0000.
- States:
  - IDLE: on accept -> REQ. stall_o=1 in the accept cycle.
  - REQ: data_req_o=1, bus outputs stable. On addr_ok -> WAIT. Request is never withdrawn before addr_ok.
  - WAIT: data_req_o=0. On data_ok, capture data_rdata_i (loads; stores leave rdata_o unchanged) -> DONE.
  - DONE: rdata_valid_o=1, stall_o=0. If mem_stall_i=0 -> IDLE at the clock edge (instruction advances); else hold.
  - DRAIN: wait for data_ok and discard it; no rdata_valid_o. data_ok -> IDLE.
- stall_o = accept | REQ | WAIT | DRAIN, i.e. 0 only in IDLE-without-accept and DONE.
- Flush handling:
  - flush in REQ: set killed. Keep req until addr_ok, then -> DRAIN.
  - flush in WAIT: data_ok same cycle -> IDLE, data discarded; else -> DRAIN.
  - flush in DONE: -> IDLE regardless of mem_stall_i; rdata_valid_o drops next cycle.
  - REQ with killed and addr_ok -> DRAIN, never WAIT.
  - killed clears on entering IDLE.
- Single outstanding transaction. No new request issues until data_ok of the previous one.
- addr_ok and data_ok in the same REQ cycle: honour addr_ok only; data_ok is not expected before addr_ok is seen and is ignored.
- Async rst mid-transaction returns to IDLE immediately. The bus side is reset by the same rst.
- Minimum latency with zero-wait bus: accept (c0), req+addr_ok (c1), data_ok (c2), DONE (c3).

Test Plan:
- Load word, addr 0x1000_0004, addr_ok c1, data_ok c2 with rdata 0xDEADBEEF -> data_req_o high c1 only; stall_o c0–c2; c3 rdata_o=0xDEADBEEF, rdata_valid_o=1, addr_low_o=0, stall_o=0.
- Store byte, addr ...03, wdata 0x000000A5 -> data_wstrb_o=1000, data_wdata_o=0xA5A5A5A5, data_wr_o=1. Store half at ...02 with 0x1234 -> wstrb 1100, wdata 0x12341234.
- Load half at addr ...01 -> misalign_o=1, data_req_o stays 0, stall_o=0, FSM stays IDLE.
- addr_ok delayed 3 cycles, then data_ok delayed 2 -> data_req_o held 4 cycles with stable addr/wdata; stall_o held until DONE.
- flush_i in WAIT, data_ok 2 cycles later with 0x55 -> DRAIN, rdata_valid_o never asserts, rdata_o unchanged, IDLE after data_ok. Repeat with flush in REQ: req held until addr_ok, then DRAIN.
- DONE with mem_stall_i=1 for 3 cycles and ex_req_i held -> rdata_valid_o stays 1, no second bus request; mem_stall_i falls -> IDLE next cycle. Async rst asserted in WAIT -> all outputs 0 immediately.
